// File: rtl/lookup_cfg_ctrl.sv
// lookup_cfg_ctrl: serialises control-plane CAM/action writes into a lookup
// stage shared with the key stream; keys are gated and lookups drained first.
module lookup_cfg_ctrl #(
    parameter int KEY_W      = 256,
    parameter int ACT_W      = 625,
    parameter int ADDR_W     = 4,
    parameter int STARVE_MAX = 16,
    parameter int BUSY_TMO   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in_valid,
    output logic              key_in_ready,
    output logic              key_out_valid,
    input  logic              action_valid,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_op,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [KEY_W-1:0]  cfg_key,
    input  logic [KEY_W-1:0]  cfg_mask,
    input  logic [ACT_W-1:0]  cfg_act,
    output logic              cam_we,
    output logic [ADDR_W-1:0] cam_wr_addr,
    output logic [KEY_W-1:0]  cam_din,
    output logic [KEY_W-1:0]  cam_mask,
    input  logic              cam_busy,
    output logic              act_we,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ACT_W-1:0]  act_din,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ACT_WR,
        S_CAM_WR,
        S_CAM_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [KEY_W-1:0]  key_q;
    logic [KEY_W-1:0]  mask_q;
    logic [ACT_W-1:0]  act_q;
    logic              busy_lk_q, busy_lk_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              rdy_q;
    logic              err_q, err_d;

    logic is_idle;
    logic freeze;
    logic drained;
    logic accept;
    logic tmo_hit;

    assign is_idle = (state_q == S_IDLE);
    assign freeze  = (starve_q == SW'(STARVE_MAX));
    assign drained = ~busy_lk_q | action_valid;
    assign accept  = is_idle & cfg_valid & (~key_in_valid | freeze);
    assign tmo_hit = (state_q == S_CAM_WAIT) & cam_busy
                   & (tmo_q == TW'(BUSY_TMO - 1));

    assign key_in_ready  = is_idle & ~freeze & drained & ~cam_busy;
    assign key_out_valid = key_in_valid & key_in_ready;

    assign cfg_ready   = rdy_q;
    assign cfg_err     = err_q;
    assign cam_wr_addr = addr_q;
    assign act_addr    = addr_q;
    assign cam_din     = key_q;
    assign cam_mask    = mask_q;
    assign act_din     = act_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state: drain, then action before CAM, then wait for CAM idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) begin
                    case (op_q)
                        2'b01:   state_d = S_CAM_WR;
                        2'b10,
                        2'b11:   state_d = S_ACT_WR;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_ACT_WR: begin
                state_d = (op_q == 2'b11) ? S_CAM_WR : S_DONE;
            end
            S_CAM_WR: begin
                if (!cam_busy) state_d = S_CAM_WAIT;
            end
            S_CAM_WAIT: begin
                if (!cam_busy || tmo_hit) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // write strobes and completion pulse decoded from state
    always_comb begin
        act_we   = 1'b0;
        cam_we   = 1'b0;
        cfg_done = 1'b0;
        case (state_q)
            S_ACT_WR: act_we   = 1'b1;
            S_CAM_WR: cam_we   = ~cam_busy;
            S_DONE:   cfg_done = 1'b1;
            default: ;
        endcase
    end

    // next values for lookup flag, starvation and busy-timeout counters
    always_comb begin
        busy_lk_d = busy_lk_q;
        if (key_out_valid) begin
            busy_lk_d = 1'b1;
        end else if (action_valid) begin
            busy_lk_d = 1'b0;
        end

        starve_d = starve_q;
        if (accept || !cfg_valid) begin
            starve_d = '0;
        end else if (is_idle && !freeze) begin
            starve_d = starve_q + SW'(1);
        end

        tmo_d = '0;
        if (state_q == S_CAM_WAIT) begin
            tmo_d = tmo_q + TW'(1);
        end

        err_d = err_q | tmo_hit;
    end

    // control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_lk_q <= 1'b0;
            starve_q  <= '0;
            tmo_q     <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            busy_lk_q <= busy_lk_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            rdy_q     <= accept;
            err_q     <= err_d;
        end
    end

    // request latch; outputs hold the last written entry between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            addr_q <= '0;
            key_q  <= '0;
            mask_q <= '0;
            act_q  <= '0;
        end else if (accept) begin
            op_q   <= cfg_op;
            addr_q <= cfg_addr;
            key_q  <= cfg_key;
            mask_q <= cfg_mask;
            act_q  <= cfg_act;
        end
    end

endmodule
